// File: rtl/soc_system_pio_pkg.sv
// Shared register map, CTRL/STATUS bit positions and pulse FSM states for the
// pulse-capable PIO peripheral.
package soc_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_WIDTH  = 3'd2;
  localparam logic [2:0] ADDR_MASK   = 3'd3;
  localparam logic [2:0] ADDR_SET    = 3'd4;
  localparam logic [2:0] ADDR_CLR    = 3'd5;
  localparam logic [2:0] ADDR_CTRL   = 3'd6;

  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_CLR_DONE = 2;
  localparam int CTRL_IRQ_EN   = 3;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_IRQ_EN = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_t;

endpackage

// File: rtl/soc_system_pulse_counter.sv
// Down-counter for the one-shot pulse: load has priority, decrement saturates at zero.
module soc_system_pulse_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/soc_system_pio_pulse_out.sv
// Avalon-MM PIO output with atomic set/clear and a hardware one-shot that XORs
// MASK onto out_port for exactly WIDTH clock cycles.
module soc_system_pio_pulse_out
  import soc_system_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  // Bus handshake: a write is accepted on every rising edge where
  // chipselect=1 and write_n=0 (no wait states); reads return the addressed
  // register one cycle later and never change state.
  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;
  logic                  start_req, abort_req, clr_done_req;
  logic                  load_cnt, cnt_zero;
  logic [CNT_WIDTH-1:0]  cnt;

  pulse_state_t          state;
  logic [DATA_WIDTH-1:0] data_q, mask_q;
  logic [CNT_WIDTH-1:0]  width_q;
  logic                  done_q, irq_en_q;

  assign wr           = chipselect && !write_n;
  assign wd           = writedata[DATA_WIDTH-1:0];
  assign start_req    = wr && (address == ADDR_CTRL) && writedata[CTRL_START];
  assign abort_req    = wr && (address == ADDR_CTRL) && writedata[CTRL_ABORT];
  assign clr_done_req = wr && (address == ADDR_CTRL) && writedata[CTRL_CLR_DONE];

  // ABORT suppresses a START in the same write, so no load happens then.
  assign load_cnt = (state == IDLE) && start_req && !abort_req && (width_q != '0);

  soc_system_pulse_counter #(.CNT_WIDTH(CNT_WIDTH)) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (load_cnt),
    .load_value (width_q - CNT_WIDTH'(1)),
    .dec        (state == ACTIVE),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      data_q   <= RESET_VALUE;
      width_q  <= '0;
      mask_q   <= '0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      readdata <= '0;
    end else begin
      if (wr) begin
        case (address)
          ADDR_DATA:  data_q   <= wd;
          ADDR_WIDTH: width_q  <= writedata[CNT_WIDTH-1:0];
          ADDR_MASK:  mask_q   <= wd;
          ADDR_SET:   data_q   <= data_q | wd;
          ADDR_CLR:   data_q   <= data_q & ~wd;
          ADDR_CTRL:  irq_en_q <= writedata[CTRL_IRQ_EN];
          default: ;
        endcase
      end

      // A hardware DONE set overrides a simultaneous CLR_DONE.
      if (clr_done_req) done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_req && !abort_req) begin
            if (width_q != '0) state <= ACTIVE;
            else               done_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (abort_req) begin
            state <= IDLE;
          end else if (cnt_zero) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      case (address)
        ADDR_DATA:   readdata <= 32'(data_q);
        ADDR_STATUS: begin
          readdata              <= '0;
          readdata[STAT_BUSY]   <= (state == ACTIVE);
          readdata[STAT_DONE]   <= done_q;
          readdata[STAT_IRQ_EN] <= irq_en_q;
        end
        ADDR_WIDTH:  readdata <= 32'(width_q);
        ADDR_MASK:   readdata <= 32'(mask_q);
        default:     readdata <= '0;
      endcase
    end
  end

  assign out_port = data_q ^ ((state == ACTIVE) ? mask_q : '0);
  assign irq      = done_q && irq_en_q;

endmodule

// File: tb/tb_soc_system_pio_pulse_out.sv
// Directed bench for the pulse-capable PIO: register access, one-shot timing,
// boundary cases (zero width, retrigger, abort, mid-pulse reset).
module tb_soc_system_pio_pulse_out;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_port;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int hi_cycles = 0;
  int s0;
  logic [31:0] rd;

  soc_system_pio_pulse_out dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Counts clock cycles in which out_port bit0 is high (pulse mask is bit0).
  always @(posedge clk) begin
    if (out_port[0] === 1'b1) hi_cycles <= hi_cycles + 1;
  end

  // driver tasks
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_out_port", out_port, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    bus_read(3'd0, rd); check("rst_data_rd", rd, 32'h0);
    bus_read(3'd1, rd); check("rst_status_rd", rd, 32'h0);

    // DATA / SET / CLR
    bus_write(3'd0, 32'h0000_000F);
    check("data_write_out", out_port, 32'h0000_000F);
    bus_write(3'd4, 32'h0000_00F0);
    bus_write(3'd5, 32'h0000_0003);
    check("setclr_out", out_port, 32'h0000_00FC);
    bus_read(3'd0, rd); check("setclr_data_rd", rd, 32'h0000_00FC);
    bus_read(3'd4, rd); check("set_reads_zero", rd, 32'h0);
    bus_read(3'd7, rd); check("addr7_reads_zero", rd, 32'h0);
    bus_write(3'd7, 32'hFFFF_FFFF);
    check("addr7_write_ignored", out_port, 32'h0000_00FC);

    // WIDTH=5 pulse on bit0 with IRQ_EN
    bus_write(3'd2, 32'd5);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, rd); check("mask_rd", rd, 32'h1);
    s0 = hi_cycles;
    bus_write(3'd6, 32'h9);
    check("pulse5_c1", out_port, 32'h0000_00FD);
    repeat (4) @(negedge clk);
    check("pulse5_c5", out_port, 32'h0000_00FD);
    @(negedge clk);
    check("pulse5_end", out_port, 32'h0000_00FC);
    check("pulse5_len", 32'(hi_cycles - s0), 32'd5);
    bus_read(3'd1, rd); check("pulse5_status", rd, 32'h6);
    check("pulse5_irq", {31'b0, irq}, 32'h1);
    bus_write(3'd6, 32'hC);
    check("clr_done_irq", {31'b0, irq}, 32'h0);
    bus_read(3'd1, rd); check("clr_done_status", rd, 32'h4);

    // WIDTH=0: DONE without pulse; START+ABORT stays idle
    bus_write(3'd6, 32'h0);
    bus_write(3'd2, 32'd0);
    s0 = hi_cycles;
    bus_write(3'd6, 32'h1);
    check("w0_out", out_port, 32'h0000_00FC);
    bus_read(3'd1, rd); check("w0_status", rd, 32'h2);
    check("w0_no_pulse", 32'(hi_cycles - s0), 32'd0);
    bus_write(3'd6, 32'h5);
    bus_read(3'd1, rd); check("clr_start_w0_done", rd, 32'h2);
    bus_write(3'd6, 32'h4);
    bus_write(3'd2, 32'd5);
    bus_write(3'd6, 32'h3);
    check("start_abort_out", out_port, 32'h0000_00FC);
    bus_read(3'd1, rd); check("start_abort_status", rd, 32'h0);

    // WIDTH=100, retrigger and WIDTH change at cycle ~10 ignored
    bus_write(3'd2, 32'd100);
    s0 = hi_cycles;
    bus_write(3'd6, 32'h1);
    repeat (8) @(negedge clk);
    bus_write(3'd2, 32'd3);
    bus_write(3'd6, 32'h1);
    bus_read(3'd1, rd); check("w100_busy", rd, 32'h1);
    repeat (110) @(negedge clk);
    check("w100_len", 32'(hi_cycles - s0), 32'd100);
    bus_read(3'd1, rd); check("w100_done", rd, 32'h2);

    // abort at cycle 20
    bus_write(3'd6, 32'h4);
    bus_write(3'd2, 32'd100);
    s0 = hi_cycles;
    bus_write(3'd6, 32'h1);
    repeat (18) @(negedge clk);
    bus_write(3'd6, 32'h2);
    repeat (5) @(negedge clk);
    check("abort_len", 32'(hi_cycles - s0), 32'd20);
    check("abort_out", out_port, 32'h0000_00FC);
    bus_read(3'd1, rd); check("abort_status", rd, 32'h0);

    // max WIDTH readback
    bus_write(3'd2, 32'hFFFF_FFFF);
    bus_read(3'd2, rd); check("width_max_rd", rd, 32'hFFFF_FFFF);

    // reset at cycle 3 of a WIDTH=10 pulse
    bus_write(3'd2, 32'd10);
    bus_write(3'd6, 32'h9);
    check("w10_c1", out_port, 32'h0000_00FD);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_out", out_port, 32'h0);
    check("midrst_readdata", readdata, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    bus_read(3'd1, rd); check("midrst_status", rd, 32'h0);
    bus_read(3'd2, rd); check("midrst_width", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
